irq_arbiter: RTL and testbench

Machine-level interrupt arbiter that drives the core's trap-entry interface. It collects 16 peripheral interrupt lines and qualifies them with per-source enables and the core's global `mstatus.MIE`. It selects the highest-priority request, holds it until the core takes the trap, and tracks the in-service interrupt until `mret`. It sits between the peripheral IRQ lines and the core/CSR file, with a small word-addressed register port on the peripheral bus.

---
 rtl/irq_pkg.sv | 26 ++
 rtl/irq_prio_enc.sv | 22 ++
 rtl/irq_arbiter.sv | 160 ++++++++++++++++
 tb/tb_irq_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants and types for the interrupt arbiter
// Purpose: source count, register byte offsets, FSM state encoding and a
// one-hot helper shared by irq_arbiter and irq_prio_enc.
// Ports: none (package).
package irq_pkg;

  localparam int NUM_SRC = 16;

  // Byte offsets; only bits [3:2] are decoded.
  localparam logic [3:0] IRQ_IE   = 4'h0;
  localparam logic [3:0] IRQ_IP   = 4'h4;
  localparam logic [3:0] IRQ_EDGE = 4'h8;
  localparam logic [3:0] IRQ_ISR  = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_t;

  function automatic logic [NUM_SRC-1:0] idx_onehot(input logic [3:0] idx);
    idx_onehot      = '0;
    idx_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - 16-bit lowest-set-bit priority encoder
// Purpose: combinational encoder; bit 0 has the highest priority.
// Ports: req_i (16 request bits), valid_o (any bit set),
//        idx_o (index of the lowest set bit, 0 when none).
module irq_prio_enc
  import irq_pkg::*;
(
  input  logic [NUM_SRC-1:0] req_i,
  output logic               valid_o,
  output logic [3:0]         idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    // Scan from the top so the lowest set bit is the last assignment.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = 4'(i);
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - machine-level interrupt arbiter for trap entry
// Purpose: synchronizes 16 interrupt lines, keeps level/edge pending bits,
// picks the lowest enabled pending source, requests a trap and tracks the
// in-service source until mret.
// Ports: clk_i/rst_i (async active-high reset); irq_src_i raw lines;
//        int_mstatus_mie_i global enable; trap_entry_en_i/trap_exit_en_i
//        core pulses; int_req_o/int_index_o registered trap request;
//        reg_wr_i/reg_rd_i/reg_addr_i/reg_wdata_i/reg_rdata_o register port.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               int_mstatus_mie_i,
  input  logic               trap_entry_en_i,
  input  logic               trap_exit_en_i,
  output logic               int_req_o,
  output logic [3:0]         int_index_o,
  input  logic               reg_wr_i,
  input  logic               reg_rd_i,
  input  logic [3:0]         reg_addr_i,
  input  logic [31:0]        reg_wdata_i,
  output logic [31:0]        reg_rdata_o
);

  logic [NUM_SRC-1:0] sync;
  logic [NUM_SRC-1:0] prev_q, ip_q, ip_d, ie_q, edge_q, edge_d;
  logic [NUM_SRC-1:0] rise, clr, cand;
  logic [1:0]         word;
  logic               wr_ie, wr_ip, wr_edge, accept;
  logic               cand_valid;
  logic [3:0]         cand_idx;
  irq_state_t         state_q;
  logic               req_q, isr_valid_q;
  logic [3:0]         index_q, isr_idx_q;
  logic [31:0]        rdata_q;
  logic               unused_bits;

  assign unused_bits = ^{reg_addr_i[1:0], reg_wdata_i[31:16]};

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync = irq_src_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][NUM_SRC-1:0] stage_q;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          stage_q <= '0;
        end else begin
          stage_q[0] <= irq_src_i;
          for (int s = 1; s < SYNC_STAGES; s++) stage_q[s] <= stage_q[s-1];
        end
      end
      assign sync = stage_q[SYNC_STAGES-1];
    end
  endgenerate

  assign word    = reg_addr_i[3:2];
  assign wr_ie   = reg_wr_i && (word == IRQ_IE[3:2]);
  assign wr_ip   = reg_wr_i && (word == IRQ_IP[3:2]);
  assign wr_edge = reg_wr_i && (word == IRQ_EDGE[3:2]);
  assign accept  = (state_q == ST_REQ) && trap_entry_en_i;

  assign edge_d = wr_edge ? reg_wdata_i[NUM_SRC-1:0] : edge_q;
  // Clears only matter for latched edge bits; level bits follow sync.
  assign clr = (wr_ip ? reg_wdata_i[NUM_SRC-1:0] : '0) |
               (accept ? idx_onehot(index_q) : '0);

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_pend
      assign rise[i] = sync[i] & ~prev_q[i];
      // Level: track sync. Edge (unchanged mode): set beats clear.
      // Newly switched to edge: drop whatever was pending.
      assign ip_d[i] = !edge_d[i] ? sync[i] :
                       edge_q[i]  ? (rise[i] | (ip_q[i] & ~clr[i])) : 1'b0;
    end
  endgenerate

  assign cand = ip_q & ie_q;

  irq_prio_enc u_prio (
    .req_i   (cand),
    .valid_o (cand_valid),
    .idx_o   (cand_idx)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q  <= '0;
      ip_q    <= '0;
      ie_q    <= '0;
      edge_q  <= '0;
      rdata_q <= '0;
    end else begin
      prev_q <= sync;
      ip_q   <= ip_d;
      edge_q <= edge_d;
      if (wr_ie) ie_q <= reg_wdata_i[NUM_SRC-1:0];
      if (reg_rd_i) begin
        case (word)
          IRQ_IE[3:2]:   rdata_q <= {16'h0, ie_q};
          IRQ_IP[3:2]:   rdata_q <= {16'h0, ip_q};
          IRQ_EDGE[3:2]: rdata_q <= {16'h0, edge_q};
          default:       rdata_q <= {27'h0, isr_valid_q, isr_idx_q};
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      index_q     <= '0;
      isr_valid_q <= 1'b0;
      isr_idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cand_valid && int_mstatus_mie_i) begin
            index_q <= cand_idx;
            req_q   <= 1'b1;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Request stays committed to index_q even if the source or its
          // enable goes away; only MIE falling withdraws it.
          if (trap_entry_en_i) begin
            isr_valid_q <= 1'b1;
            isr_idx_q   <= index_q;
            req_q       <= 1'b0;
            state_q     <= ST_SERVICE;
          end else if (!int_mstatus_mie_i) begin
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_SERVICE: begin
          if (trap_exit_en_i) begin
            isr_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign int_req_o   = req_q;
  assign int_index_o = index_q;
  assign reg_rdata_o = rdata_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// tb/tb_irq_arbiter.sv - self-checking bench for irq_arbiter
module tb_irq_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] irq_src_i;
  logic        int_mstatus_mie_i;
  logic        trap_entry_en_i;
  logic        trap_exit_en_i;
  logic        int_req_o;
  logic [3:0]  int_index_o;
  logic        reg_wr_i;
  logic        reg_rd_i;
  logic [3:0]  reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic [31:0] reg_rdata_o;

  always #5 clk_i = ~clk_i;

  irq_arbiter #(.SYNC_STAGES(2)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .irq_src_i         (irq_src_i),
    .int_mstatus_mie_i (int_mstatus_mie_i),
    .trap_entry_en_i   (trap_entry_en_i),
    .trap_exit_en_i    (trap_exit_en_i),
    .int_req_o         (int_req_o),
    .int_index_o       (int_index_o),
    .reg_wr_i          (reg_wr_i),
    .reg_rd_i          (reg_rd_i),
    .reg_addr_i        (reg_addr_i),
    .reg_wdata_i       (reg_wdata_i),
    .reg_rdata_o       (reg_rdata_o)
  );

  typedef struct {
    logic [15:0] src;
    logic [15:0] ie;
    logic        mie;
    logic        exp_req;
    logic [3:0]  exp_idx;
  } vec_t;

  vec_t vecs[7];
  int   n_total = 0;
  int   n_pass  = 0;
  logic [31:0] rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
    reg_wr_i = 1'b1; reg_addr_i = a; reg_wdata_i = d;
    step(1);
    reg_wr_i = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] a, output logic [31:0] d);
    reg_rd_i = 1'b1; reg_addr_i = a;
    step(1);
    reg_rd_i = 1'b0;
    d = reg_rdata_o;
  endtask

  task automatic pulse_entry();
    trap_entry_en_i = 1'b1; step(1); trap_entry_en_i = 1'b0;
  endtask

  task automatic pulse_exit();
    trap_exit_en_i = 1'b1; step(1); trap_exit_en_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{src: 16'h0008, ie: 16'h0008, mie: 1'b1, exp_req: 1'b1, exp_idx: 4'd3};
    vecs[1] = '{src: 16'h0220, ie: 16'hFFFF, mie: 1'b1, exp_req: 1'b1, exp_idx: 4'd5};
    vecs[2] = '{src: 16'h8000, ie: 16'h8000, mie: 1'b1, exp_req: 1'b1, exp_idx: 4'd15};
    vecs[3] = '{src: 16'h0010, ie: 16'h0000, mie: 1'b1, exp_req: 1'b0, exp_idx: 4'd0};
    vecs[4] = '{src: 16'h0004, ie: 16'h0004, mie: 1'b0, exp_req: 1'b0, exp_idx: 4'd0};
    vecs[5] = '{src: 16'hFFFF, ie: 16'hFFFE, mie: 1'b1, exp_req: 1'b1, exp_idx: 4'd1};
    vecs[6] = '{src: 16'h0300, ie: 16'h0200, mie: 1'b1, exp_req: 1'b1, exp_idx: 4'd9};

    rst_i = 1'b1; irq_src_i = '0; int_mstatus_mie_i = 1'b0;
    trap_entry_en_i = 1'b0; trap_exit_en_i = 1'b0;
    reg_wr_i = 1'b0; reg_rd_i = 1'b0; reg_addr_i = '0; reg_wdata_i = '0;
    step(3);
    rst_i = 1'b0;
    step(1);

    // Reset state
    check("rst_req", {31'h0, int_req_o}, 32'h0);
    check("rst_idx", {28'h0, int_index_o}, 32'h0);
    check("rst_rdata", reg_rdata_o, 32'h0);
    reg_read(4'h0, rd); check("rst_ie", rd, 32'h0);
    reg_read(4'h4, rd); check("rst_ip", rd, 32'h0);
    reg_read(4'h8, rd); check("rst_edge", rd, 32'h0);
    reg_read(4'hC, rd); check("rst_isr", rd, 32'h0);

    // Table-driven level vectors with exact 4-cycle latency
    for (int v = 0; v < 7; v++) begin
      reg_write(4'h0, {16'h0, vecs[v].ie});
      int_mstatus_mie_i = vecs[v].mie;
      irq_src_i = vecs[v].src;
      step(3);
      check($sformatf("vec%0d_req_early", v), {31'h0, int_req_o}, 32'h0);
      step(1);
      check($sformatf("vec%0d_req", v), {31'h0, int_req_o}, {31'h0, vecs[v].exp_req});
      if (vecs[v].exp_req) begin
        check($sformatf("vec%0d_idx", v), {28'h0, int_index_o}, {28'h0, vecs[v].exp_idx});
        pulse_entry();
        check($sformatf("vec%0d_req_after_entry", v), {31'h0, int_req_o}, 32'h0);
      end
      irq_src_i = '0;
      step(4);
      if (vecs[v].exp_req) begin
        pulse_exit();
        step(2);
        check($sformatf("vec%0d_req_after_exit", v), {31'h0, int_req_o}, 32'h0);
      end
    end

    // Level source with ISR readback
    int_mstatus_mie_i = 1'b1;
    reg_write(4'h0, 32'h0008);
    irq_src_i = 16'h0008;
    step(4);
    check("lvl_req", {31'h0, int_req_o}, 32'h1);
    check("lvl_idx", {28'h0, int_index_o}, 32'h3);
    pulse_entry();
    check("lvl_req_drop", {31'h0, int_req_o}, 32'h0);
    reg_read(4'hC, rd); check("lvl_isr_service", rd, 32'h13);
    irq_src_i = '0;
    step(4);
    pulse_exit();
    reg_read(4'hC, rd); check("lvl_isr_exit", rd, 32'h03);

    // Priority, then re-arbitration of the remaining source after exit
    reg_write(4'h0, 32'h0220);
    irq_src_i = 16'h0220;
    step(4);
    check("prio_idx", {28'h0, int_index_o}, 32'h5);
    pulse_entry();
    irq_src_i = 16'h0200;
    step(4);
    pulse_exit();
    check("prio_req_exit0", {31'h0, int_req_o}, 32'h0);
    step(1);
    check("prio_req_exit1", {31'h0, int_req_o}, 32'h1);
    check("prio_idx2", {28'h0, int_index_o}, 32'h9);
    pulse_entry();
    irq_src_i = '0;
    step(4);
    pulse_exit();
    step(2);

    // Edge latch, W1C, then request on enable
    reg_write(4'h0, 32'h0);
    reg_write(4'h8, 32'h0001);
    irq_src_i = 16'h0001; step(1); irq_src_i = '0;
    step(4);
    check("edge_no_req", {31'h0, int_req_o}, 32'h0);
    reg_read(4'h4, rd); check("edge_ip_set", rd, 32'h0001);
    reg_write(4'h4, 32'h0001);
    reg_read(4'h4, rd); check("edge_ip_w1c", rd, 32'h0);
    irq_src_i = 16'h0001; step(1); irq_src_i = '0;
    step(4);
    reg_write(4'h0, 32'h0001);
    step(1);
    check("edge_req", {31'h0, int_req_o}, 32'h1);
    check("edge_idx", {28'h0, int_index_o}, 32'h0);
    pulse_entry();
    reg_read(4'h4, rd); check("edge_ip_accept_clr", rd, 32'h0);
    pulse_exit();
    step(2);
    check("edge_no_rereq", {31'h0, int_req_o}, 32'h0);

    // Set/clear collision on edge source 2: W1C lands on the detect cycle
    reg_write(4'h8, 32'h0004);
    irq_src_i = 16'h0004;
    step(2);
    reg_write(4'h4, 32'h0004);
    reg_read(4'h4, rd); check("coll_set_wins", rd, 32'h0004);
    reg_write(4'h4, 32'h0004);
    reg_read(4'h4, rd); check("coll_later_clr", rd, 32'h0);
    irq_src_i = '0;

    // MIE gating in REQ
    reg_write(4'h8, 32'h0);
    reg_write(4'h0, 32'h0040);
    irq_src_i = 16'h0040;
    step(4);
    check("mie_req", {31'h0, int_req_o}, 32'h1);
    int_mstatus_mie_i = 1'b0;
    step(1);
    check("mie_drop", {31'h0, int_req_o}, 32'h0);
    int_mstatus_mie_i = 1'b1;
    step(2);
    check("mie_rereq", {31'h0, int_req_o}, 32'h1);
    check("mie_idx", {28'h0, int_index_o}, 32'h6);
    pulse_entry();

    // Reset while in SERVICE with a latched edge bit
    reg_write(4'h8, 32'h0100);
    irq_src_i = 16'h0140; step(1); irq_src_i = 16'h0040;
    step(4);
    reg_read(4'h4, rd); check("svc_ip_before_rst", rd, 32'h0140);
    rst_i = 1'b1;
    #1;
    check("mrst_req", {31'h0, int_req_o}, 32'h0);
    check("mrst_idx", {28'h0, int_index_o}, 32'h0);
    step(1);
    rst_i = 1'b0;
    reg_read(4'hC, rd); check("mrst_isr", rd, 32'h0);
    reg_read(4'h0, rd); check("mrst_ie", rd, 32'h0);
    reg_read(4'h8, rd); check("mrst_edge", rd, 32'h0);
    reg_read(4'h4, rd); check("mrst_ip_edge_bit", rd & 32'h0100, 32'h0);
    step(6);
    check("mrst_no_req", {31'h0, int_req_o}, 32'h0);
    reg_write(4'h0, 32'h0040);
    step(1);
    check("mrst_req_after_ie", {31'h0, int_req_o}, 32'h1);
    check("mrst_idx_after_ie", {28'h0, int_index_o}, 32'h6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
